// File: rtl/maze_probe_arbiter.sv
// Round-robin arbiter that shares one background ROM among N sprite controllers.
// Each grant issues four neighbour reads and returns a {left,right,up,down} wall mask.
module maze_probe_arbiter #(
  parameter int          N          = 4,
  parameter int          WIDTH      = 320,
  parameter int          HEIGHT     = 240,
  parameter int          ROM_LAT    = 1,
  parameter logic [11:0] WALL_COLOR = 12'h000,
  localparam int         IW         = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [N-1:0]    req,
  input  logic [9*N-1:0]  x_in,
  input  logic [9*N-1:0]  y_in,
  output logic [16:0]     rom_addr,
  input  logic [11:0]     rom_q,
  output logic [3:0]      wall_mask,
  output logic [N-1:0]    done,
  output logic [IW-1:0]   grant_id,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           last_q;
  logic [8:0]              x_q, y_q;
  logic [3:0]              oob_q;
  logic [1:0]              cnt;
  logic [3:0]              shadow;
  // vld_pipe[j]/dir_pipe[j]: the address on rom_addr j cycles ago was a probe of that direction
  logic [ROM_LAT:0]        vld_pipe;
  logic [ROM_LAT:0][1:0]   dir_pipe;

  logic                    win_vld;
  logic [IW-1:0]           win_id;
  logic [8:0]              x_sel, y_sel;
  logic [3:0]              oob_sel;
  logic                    cap_vld, cap_bit, cap_last;
  logic [1:0]              cap_dir;

  function automatic logic [3:0] oob_of(input logic [8:0] x, input logic [8:0] y);
    return {x == 9'd0, x == 9'(WIDTH-1), y == 9'd0, y == 9'(HEIGHT-1)};
  endfunction

  // dir: 0 left, 1 right, 2 up, 3 down; mask bit for dir d is 3-d
  function automatic logic [16:0] probe_addr(input logic [8:0] x, input logic [8:0] y,
                                             input logic [1:0] dir, input logic [3:0] oob);
    logic [17:0] xx, yy, a;
    xx = {9'd0, x};
    yy = {9'd0, y};
    a  = '0;
    unique case (dir)
      2'd0: a = 18'(WIDTH) * yy + xx - 18'd1;
      2'd1: a = 18'(WIDTH) * yy + xx + 18'd1;
      2'd2: a = 18'(WIDTH) * (yy - 18'd1) + xx;
      2'd3: a = 18'(WIDTH) * (yy + 18'd1) + xx;
    endcase
    return oob[2'd3 - dir] ? 17'd0 : a[16:0];
  endfunction

  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int j = 1; j <= N; j++) begin
      int idx;
      idx = (int'(last_q) + j) % N;
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_id  = IW'(idx);
      end
    end
  end

  assign x_sel    = x_in[9*int'(win_id) +: 9];
  assign y_sel    = y_in[9*int'(win_id) +: 9];
  assign oob_sel  = oob_of(x_sel, y_sel);

  assign cap_vld  = vld_pipe[ROM_LAT];
  assign cap_dir  = dir_pipe[ROM_LAT];
  assign cap_bit  = oob_q[2'd3 - cap_dir] | (rom_q == WALL_COLOR);
  assign cap_last = cap_vld && (cap_dir == 2'd3);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (win_vld) state_d = ISSUE;
      ISSUE: if (cnt == 2'd3) state_d = DRAIN;
      DRAIN: if (cap_last) state_d = DONE;
      DONE:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      last_q    <= IW'(N-1);
      x_q       <= '0;
      y_q       <= '0;
      oob_q     <= '0;
      cnt       <= '0;
      shadow    <= '0;
      vld_pipe  <= '0;
      dir_pipe  <= '0;
      rom_addr  <= '0;
      wall_mask <= '0;
      done      <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
    end else begin
      state_q               <= state_d;
      vld_pipe[ROM_LAT:1]   <= vld_pipe[ROM_LAT-1:0];
      dir_pipe[ROM_LAT:1]   <= dir_pipe[ROM_LAT-1:0];
      vld_pipe[0]           <= 1'b0;

      unique case (state_q)
        IDLE: if (win_vld) begin
          x_q         <= x_sel;
          y_q         <= y_sel;
          oob_q       <= oob_sel;
          grant_id    <= win_id;
          last_q      <= win_id;
          busy        <= 1'b1;
          cnt         <= 2'd0;
          shadow      <= '0;
          rom_addr    <= probe_addr(x_sel, y_sel, 2'd0, oob_sel);
          vld_pipe[0] <= 1'b1;
          dir_pipe[0] <= 2'd0;
        end
        ISSUE: begin
          if (cnt == 2'd3) begin
            rom_addr <= '0;
          end else begin
            cnt         <= cnt + 2'd1;
            rom_addr    <= probe_addr(x_q, y_q, cnt + 2'd1, oob_q);
            vld_pipe[0] <= 1'b1;
            dir_pipe[0] <= cnt + 2'd1;
          end
        end
        DRAIN: ;
        DONE: begin
          done <= '0;
          busy <= 1'b0;
        end
      endcase

      if (cap_vld) begin
        shadow[2'd3 - cap_dir] <= cap_bit;
        if (cap_last) begin
          wall_mask        <= {shadow[3:1], cap_bit};
          done             <= '0;
          done[grant_id]   <= 1'b1;
        end
      end
    end
  end

endmodule
